// File: rtl/coreaxitoahbl_ram_rd_ctrl_if.sv
// coreaxitoahbl_ram_rd_ctrl_if: command, RAM read port and output stream of the RAM read controller
interface coreaxitoahbl_ram_rd_ctrl_if #(
  parameter int AXI_DWIDTH = 64,
  parameter int AXI_LWIDTH = 4
);
  logic                  start;
  logic [AXI_LWIDTH-1:0] startAddr;
  logic [AXI_LWIDTH-1:0] beatCnt;
  logic                  busy;
  logic [AXI_LWIDTH-1:0] rdAddr;
  logic [AXI_DWIDTH-1:0] rdData;
  logic [AXI_DWIDTH-1:0] outData;
  logic                  outValid;
  logic                  outReady;
  logic                  outLast;
  logic                  done;
  modport master (
    output start, startAddr, beatCnt, rdData, outReady,
    input  busy, rdAddr, outData, outValid, outLast, done
  );
  modport slave (
    input  start, startAddr, beatCnt, rdData, outReady,
    output busy, rdAddr, outData, outValid, outLast, done
  );
endinterface

// File: rtl/coreaxitoahbl_ram_rd_ctrl.sv
// coreaxitoahbl_ram_rd_ctrl: burst reader of the data buffer RAM feeding a 2-entry valid/ready stream
module coreaxitoahbl_ram_rd_ctrl #(
  parameter int AXI_DWIDTH = 64,
  parameter int AXI_LWIDTH = 4
) (
  input logic rdCLK,
  input logic RESETN,
  coreaxitoahbl_ram_rd_ctrl_if.slave bus
);
  localparam int LW = AXI_LWIDTH;
  localparam int DW = AXI_DWIDTH;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t        state_q, state_d;
  logic [LW-1:0] ptr_q, ptr_d, last_q, last_d, beat_q, beat_d, rd_addr_q;
  logic [LW:0]   left_q, left_d;
  logic          done_q, done_d, inflight_q, wp_q, rp_q, pop, issue;
  logic [1:0]    cnt_q;
  logic [2:0]    occ;
  logic [DW-1:0] mem_q [2];
  assign pop          = bus.outValid & bus.outReady;
  assign occ          = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue        = (state_q == READ) && (left_q != '0) && (occ < 3'd2);
  assign bus.rdAddr   = issue ? ptr_q : rd_addr_q;
  assign bus.outValid = cnt_q != 2'd0;
  assign bus.outData  = mem_q[rp_q];
  assign bus.outLast  = bus.outValid && (beat_q == last_q);
  assign bus.busy     = state_q != IDLE;
  assign bus.done     = done_q;
  // burst sequencing: latch command, count issued reads, finish on the last handshake
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    left_d  = left_q;
    last_d  = last_q;
    beat_d  = pop ? beat_q + LW'(1) : beat_q;
    done_d  = 1'b0;
    if (state_q == IDLE && bus.start) begin
      state_d = READ;
      ptr_d   = bus.startAddr;
      left_d  = {1'b0, bus.beatCnt} + (LW+1)'(1);
      last_d  = bus.beatCnt;
      beat_d  = '0;
    end
    if (issue) begin
      ptr_d  = ptr_q + LW'(1);
      left_d = left_q - (LW+1)'(1);
      state_d = (left_q == (LW+1)'(1)) ? DRAIN : state_q;
    end
    if (state_q == DRAIN && pop && bus.outLast) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end
  // control registers
  always_ff @(posedge rdCLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      left_q     <= '0;
      last_q     <= '0;
      beat_q     <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      left_q     <= left_d;
      last_q     <= last_d;
      beat_q     <= beat_d;
      done_q     <= done_d;
      inflight_q <= issue;
      rd_addr_q  <= bus.rdAddr;
    end
  end
  // 2-entry output FIFO: capture only the read that is in flight, pop on handshake
  always_ff @(posedge rdCLK or negedge RESETN) begin
    if (!RESETN) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (inflight_q) begin
        mem_q[wp_q] <= bus.rdData;
        wp_q        <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_coreaxitoahbl_ram_rd_ctrl.sv
// tb_coreaxitoahbl_ram_rd_ctrl: directed checks of the RAM read controller against a registered RAM model
module tb_coreaxitoahbl_ram_rd_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int dones = 0;
  logic [63:0] mem [16];
  logic [63:0] rd_q;
  logic [63:0] got_d [$];
  logic        got_l [$];
  always #5 clk = ~clk;
  coreaxitoahbl_ram_rd_ctrl_if #(.AXI_DWIDTH(64), .AXI_LWIDTH(4)) bus ();
  coreaxitoahbl_ram_rd_ctrl #(.AXI_DWIDTH(64), .AXI_LWIDTH(4)) dut (
    .rdCLK(clk), .RESETN(rst_n), .bus(bus)
  );
  // RAM model with registered read address
  always @(posedge clk) rd_q <= mem[bus.rdAddr];
  assign bus.rdData = rd_q;
  // stream monitor
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.outValid && bus.outReady) begin
        got_d.push_back(bus.outData);
        got_l.push_back(bus.outLast);
      end
      if (bus.done) dones++;
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [3:0] a, input logic [3:0] c);
    bus.startAddr = a;
    bus.beatCnt   = c;
    bus.start     = 1'b1;
    cyc(1);
    bus.start     = 1'b0;
  endtask
  task automatic wait_done();
    int i;
    i = 0;
    while (!bus.done && i < 60) begin
      cyc(1);
      i++;
    end
    chk("done_seen", {63'd0, bus.done}, 64'd1);
  endtask
  task automatic chk_q(input int base, input int n, input int a0);
    logic [3:0] a;
    chk("beat_count", 64'(got_d.size() - base), 64'(n));
    for (int k = 0; k < n && base + k < got_d.size(); k++) begin
      a = 4'(a0 + k);
      chk("beat_data", got_d[base+k], mem[a]);
      chk("beat_last", {63'd0, got_l[base+k]}, {63'd0, k == n - 1});
    end
  endtask
  task automatic run_stream(input logic [3:0] a, input logic [3:0] c);
    int d0;
    logic [3:0] x;
    d0 = dones;
    go(a, c);
    cyc(2);
    for (int k = 0; k <= int'(c); k++) begin
      x = a + 4'(k);
      chk("stream_valid", {63'd0, bus.outValid}, 64'd1);
      chk("stream_data", bus.outData, mem[x]);
      chk("stream_last", {63'd0, bus.outLast}, {63'd0, k == int'(c)});
      cyc(1);
    end
    chk("stream_done", {63'd0, bus.done}, 64'd1);
    chk("stream_busy", {63'd0, bus.busy}, 64'd0);
    cyc(1);
    chk("stream_done_cnt", 64'(dones - d0), 64'd1);
    chk("stream_done_low", {63'd0, bus.done}, 64'd0);
  endtask
  initial begin
    int d0;
    int b0;
    logic [7:0] pat;
    logic pv, pr;
    logic [63:0] pd;
    for (int i = 0; i < 16; i++) mem[i] = 64'hD000 + 64'(i);
    mem[5] = 64'hA5A5;
    bus.start = 1'b0;
    bus.startAddr = '0;
    bus.beatCnt = '0;
    bus.outReady = 1'b0;
    cyc(2);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_rdAddr", {60'd0, bus.rdAddr}, 64'd0);
    chk("rst_outData", bus.outData, 64'd0);
    chk("rst_outValid", {63'd0, bus.outValid}, 64'd0);
    chk("rst_outLast", {63'd0, bus.outLast}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    rst_n = 1'b1;
    cyc(1);
    // single beat
    bus.outReady = 1'b1;
    go(4'd5, 4'd0);
    chk("s1_rdAddr", {60'd0, bus.rdAddr}, 64'd5);
    chk("s1_busy", {63'd0, bus.busy}, 64'd1);
    cyc(1);
    chk("s1_valid_early", {63'd0, bus.outValid}, 64'd0);
    cyc(1);
    chk("s1_valid", {63'd0, bus.outValid}, 64'd1);
    chk("s1_data", bus.outData, 64'hA5A5);
    chk("s1_last", {63'd0, bus.outLast}, 64'd1);
    chk("s1_done_early", {63'd0, bus.done}, 64'd0);
    cyc(1);
    chk("s1_done", {63'd0, bus.done}, 64'd1);
    chk("s1_busy_low", {63'd0, bus.busy}, 64'd0);
    chk("s1_valid_low", {63'd0, bus.outValid}, 64'd0);
    cyc(1);
    chk("s1_done_low", {63'd0, bus.done}, 64'd0);
    mem[5] = 64'hD005;
    // streaming and wrap-around
    run_stream(4'd2, 4'd3);
    run_stream(4'd14, 4'd3);
    // back-pressure: ready low for 5 cycles from start, then a toggling pattern
    b0 = got_d.size();
    d0 = dones;
    bus.outReady = 1'b0;
    go(4'd6, 4'd7);
    chk("bp_rdAddr0", {60'd0, bus.rdAddr}, 64'd6);
    cyc(1);
    chk("bp_rdAddr1", {60'd0, bus.rdAddr}, 64'd7);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("bp_stall_rdAddr", {60'd0, bus.rdAddr}, 64'd7);
      chk("bp_stall_valid", {63'd0, bus.outValid}, 64'd1);
      chk("bp_stall_data", bus.outData, mem[6]);
    end
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      bus.outReady = pat[i];
      #1;
      pv = bus.outValid;
      pr = pat[i];
      pd = bus.outData;
      cyc(1);
      if (pv && !pr) begin
        chk("bp_hold_valid", {63'd0, bus.outValid}, 64'd1);
        chk("bp_hold_data", bus.outData, pd);
      end
    end
    bus.outReady = 1'b1;
    wait_done();
    cyc(1);
    chk("bp_done_cnt", 64'(dones - d0), 64'd1);
    chk_q(b0, 8, 6);
    // second start during a burst is ignored
    b0 = got_d.size();
    d0 = dones;
    go(4'd0, 4'd3);
    bus.startAddr = 4'd9;
    bus.beatCnt = 4'd0;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    wait_done();
    cyc(1);
    chk("cmd_done_cnt", 64'(dones - d0), 64'd1);
    chk_q(b0, 4, 0);
    cyc(3);
    chk("cmd_idle", {63'd0, bus.busy}, 64'd0);
    // full-depth burst
    b0 = got_d.size();
    go(4'd3, 4'd15);
    wait_done();
    cyc(1);
    chk_q(b0, 16, 3);
    // reset mid-burst
    d0 = dones;
    go(4'd4, 4'd5);
    cyc(4);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", {63'd0, bus.busy}, 64'd0);
    chk("mr_rdAddr", {60'd0, bus.rdAddr}, 64'd0);
    chk("mr_outData", bus.outData, 64'd0);
    chk("mr_outValid", {63'd0, bus.outValid}, 64'd0);
    chk("mr_outLast", {63'd0, bus.outLast}, 64'd0);
    chk("mr_done", {63'd0, bus.done}, 64'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    chk("mr_no_done", 64'(dones - d0), 64'd0);
    chk("mr_no_valid", {63'd0, bus.outValid}, 64'd0);
    b0 = got_d.size();
    go(4'd0, 4'd1);
    wait_done();
    cyc(1);
    chk_q(b0, 2, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
